frame_motion_ctrl: RTL and testbench

- Frame-synchronous motion controller for the on-screen box overlay in the VGA top level.
- Merges direction requests from the four board buttons and from PS/2 arrow keys, which it decodes from scan-code bytes.
- Applies exactly one position update per frame, with speed ramping and clamping to screen bounds.
- Outputs box_x/box_y to the overlay compare logic. It replaces the per-cycle, unclamped-step update loop.

---
 rtl/frame_motion_ctrl.sv | 179 +++++++++++++++++
 tb/tb_frame_motion_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/frame_motion_ctrl.sv
`default_nettype none
// ============================================================================
// frame_motion_ctrl -- once-per-frame box mover (buttons + PS/2 arrows), speed ramp, clamp
// Revision: 1.0
// ============================================================================
module frame_motion_ctrl #(
  parameter int VIDEO_WIDTH  = 640,
  parameter int VIDEO_HEIGHT = 480,
  parameter int BOX_SIZE     = 50,
  parameter int INIT_X       = 100,
  parameter int INIT_Y       = 100,
  parameter int MAX_SPEED    = 4,
  parameter int RAMP_FRAMES  = 8,
  parameter int COORD_W      = 10
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               screen_end_i,
  input  logic               btn_up_i,
  input  logic               btn_right_i,
  input  logic               btn_down_i,
  input  logic               btn_left_i,
  input  logic [7:0]         rx_data_i,
  input  logic               read_data_i,
  output logic [COORD_W-1:0] box_x_o,
  output logic [COORD_W-1:0] box_y_o,
  output logic [3:0]         key_held_o,
  output logic [2:0]         speed_o,
  output logic               frame_tick_o,
  output logic               moving_o
);

  localparam int HOLD_W = (RAMP_FRAMES > 1) ? $clog2(RAMP_FRAMES) : 1;
  localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(RAMP_FRAMES - 1);
  localparam logic [2:0]         SPEED_MAX = 3'(MAX_SPEED);
  localparam logic [COORD_W:0]   X_MAX     = (COORD_W+1)'(VIDEO_WIDTH - BOX_SIZE);
  localparam logic [COORD_W:0]   Y_MAX     = (COORD_W+1)'(VIDEO_HEIGHT - BOX_SIZE);

  typedef enum logic [1:0] {
    K_IDLE    = 2'd0,
    K_EXT     = 2'd1,
    K_EXT_BRK = 2'd2,
    K_BRK     = 2'd3
  } kstate_e;

  kstate_e             kstate_q;
  logic                se_prev_q;
  logic [COORD_W-1:0]  box_x_q, box_y_q;
  logic [COORD_W-1:0]  box_x_d, box_y_d;
  logic [2:0]          speed_q;
  logic [HOLD_W-1:0]   hold_cnt_q;
  logic [3:0]          key_held_q;
  logic                frame_tick_q;
  logic                moving_q;

  logic                upd_w;
  logic                req_u_w, req_r_w, req_d_w, req_l_w;
  logic                x_pos_w, x_neg_w, y_pos_w, y_neg_w;
  logic [COORD_W:0]    step_w;
  logic [COORD_W:0]    x_sum_w, x_dif_w, y_sum_w, y_dif_w;

  assign upd_w   = screen_end_i & ~se_prev_q;

  assign req_u_w = btn_up_i    | key_held_q[3];
  assign req_r_w = btn_right_i | key_held_q[2];
  assign req_d_w = btn_down_i  | key_held_q[1];
  assign req_l_w = btn_left_i  | key_held_q[0];

  // Opposing requests cancel to a zero net direction.
  assign x_pos_w = req_r_w & ~req_l_w;
  assign x_neg_w = req_l_w & ~req_r_w;
  assign y_pos_w = req_d_w & ~req_u_w;
  assign y_neg_w = req_u_w & ~req_d_w;

  assign step_w  = {{(COORD_W-2){1'b0}}, speed_q};
  assign x_sum_w = {1'b0, box_x_q} + step_w;
  assign x_dif_w = {1'b0, box_x_q} - step_w;
  assign y_sum_w = {1'b0, box_y_q} + step_w;
  assign y_dif_w = {1'b0, box_y_q} - step_w;

  always_comb begin
    box_x_d = box_x_q;
    if (x_pos_w) begin
      box_x_d = (x_sum_w > X_MAX) ? X_MAX[COORD_W-1:0] : x_sum_w[COORD_W-1:0];
    end else if (x_neg_w) begin
      box_x_d = ({1'b0, box_x_q} < step_w) ? '0 : x_dif_w[COORD_W-1:0];
    end
  end

  always_comb begin
    box_y_d = box_y_q;
    if (y_pos_w) begin
      box_y_d = (y_sum_w > Y_MAX) ? Y_MAX[COORD_W-1:0] : y_sum_w[COORD_W-1:0];
    end else if (y_neg_w) begin
      box_y_d = ({1'b0, box_y_q} < step_w) ? '0 : y_dif_w[COORD_W-1:0];
    end
  end

  // Frame update, speed ramp and registered status outputs.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      se_prev_q    <= 1'b1;
      box_x_q      <= COORD_W'(INIT_X);
      box_y_q      <= COORD_W'(INIT_Y);
      speed_q      <= 3'd1;
      hold_cnt_q   <= '0;
      frame_tick_q <= 1'b0;
      moving_q     <= 1'b0;
    end else begin
      se_prev_q    <= screen_end_i;
      frame_tick_q <= upd_w;
      if (upd_w) begin
        box_x_q <= box_x_d;
        box_y_q <= box_y_d;
        if (x_pos_w | x_neg_w | y_pos_w | y_neg_w) begin
          moving_q <= 1'b1;
          if (hold_cnt_q == HOLD_LAST) begin
            hold_cnt_q <= '0;
            if (speed_q < SPEED_MAX) speed_q <= speed_q + 3'd1;
          end else begin
            hold_cnt_q <= hold_cnt_q + 1'b1;
          end
        end else begin
          moving_q   <= 1'b0;
          speed_q    <= 3'd1;
          hold_cnt_q <= '0;
        end
      end
    end
  end

  // PS/2 scan-code decoder: only extended make/break codes touch the arrow flags.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      kstate_q   <= K_IDLE;
      key_held_q <= 4'b0000;
    end else if (read_data_i) begin
      case (kstate_q)
        K_IDLE: begin
          if (rx_data_i == 8'hE0)      kstate_q <= K_EXT;
          else if (rx_data_i == 8'hF0) kstate_q <= K_BRK;
          else                         kstate_q <= K_IDLE;
        end
        K_EXT: begin
          kstate_q <= K_IDLE;
          case (rx_data_i)
            8'hF0: kstate_q <= K_EXT_BRK;
            8'hE0: kstate_q <= K_EXT;
            8'h75: key_held_q[3] <= 1'b1;
            8'h74: key_held_q[2] <= 1'b1;
            8'h72: key_held_q[1] <= 1'b1;
            8'h6B: key_held_q[0] <= 1'b1;
            default: ;
          endcase
        end
        K_EXT_BRK: begin
          kstate_q <= K_IDLE;
          case (rx_data_i)
            8'h75: key_held_q[3] <= 1'b0;
            8'h74: key_held_q[2] <= 1'b0;
            8'h72: key_held_q[1] <= 1'b0;
            8'h6B: key_held_q[0] <= 1'b0;
            default: ;
          endcase
        end
        default: kstate_q <= K_IDLE;
      endcase
    end
  end

  assign box_x_o      = box_x_q;
  assign box_y_o      = box_y_q;
  assign key_held_o   = key_held_q;
  assign speed_o      = speed_q;
  assign frame_tick_o = frame_tick_q;
  assign moving_o     = moving_q;

endmodule
`default_nettype wire

// File: tb/tb_frame_motion_ctrl.sv
`default_nettype none
// ============================================================================
// tb_frame_motion_ctrl -- directed self-checking bench for frame_motion_ctrl
// Revision: 1.0
// ============================================================================
module tb_frame_motion_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       screen_end = 1'b0;
  logic       btn_up = 1'b0, btn_right = 1'b0, btn_down = 1'b0, btn_left = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       read_data = 1'b0;
  logic [9:0] box_x, box_y;
  logic [3:0] key_held;
  logic [2:0] speed;
  logic       frame_tick, moving;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  frame_motion_ctrl dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .screen_end_i (screen_end),
    .btn_up_i     (btn_up),
    .btn_right_i  (btn_right),
    .btn_down_i   (btn_down),
    .btn_left_i   (btn_left),
    .rx_data_i    (rx_data),
    .read_data_i  (read_data),
    .box_x_o      (box_x),
    .box_y_o      (box_y),
    .key_held_o   (key_held),
    .speed_o      (speed),
    .frame_tick_o (frame_tick),
    .moving_o     (moving)
  );

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    screen_end = 1'b0;
    btn_up = 0; btn_right = 0; btn_down = 0; btn_left = 0;
    read_data = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  // screen_end high for 'hi' cycles then low for 4; frame_tick counted at negedges.
  task automatic do_frame(input int hi, output int ticks);
    ticks = 0;
    for (int i = 0; i < hi + 4; i++) begin
      @(negedge clk);
      screen_end = (i < hi);
      if (frame_tick === 1'b1) ticks++;
    end
    screen_end = 1'b0;
  endtask

  task automatic frames(input int n);
    int t;
    for (int i = 0; i < n; i++) do_frame(2, t);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    read_data = 1'b1;
    @(negedge clk);
    read_data = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (box_x !== 10'd100) begin n_bad++; $display("FAIL reset_box_x got %0d want 100", box_x); end
    n_cmp++; if (box_y !== 10'd100) begin n_bad++; $display("FAIL reset_box_y got %0d want 100", box_y); end
    n_cmp++; if (speed !== 3'd1) begin n_bad++; $display("FAIL reset_speed got %0d want 1", speed); end
    n_cmp++; if (key_held !== 4'b0000) begin n_bad++; $display("FAIL reset_key_held got %b want 0000", key_held); end
    n_cmp++; if (frame_tick !== 1'b0 || moving !== 1'b0) begin n_bad++; $display("FAIL reset_flags got tick=%b mov=%b want 0 0", frame_tick, moving); end
  endtask

  task automatic test_ramp();
    logic [9:0] exp_x [4] = '{10'd108, 10'd124, 10'd148, 10'd152};
    int         at    [4] = '{8, 16, 24, 25};
    int         done = 0;
    do_reset();
    btn_right = 1'b1;
    for (int k = 0; k < 4; k++) begin
      frames(at[k] - done);
      done = at[k];
      n_cmp++; if (box_x !== exp_x[k]) begin n_bad++; $display("FAIL ramp_x_f%0d got %0d want %0d", at[k], box_x, exp_x[k]); end
    end
    n_cmp++; if (speed !== 3'd4) begin n_bad++; $display("FAIL ramp_speed got %0d want 4", speed); end
    n_cmp++; if (box_y !== 10'd100) begin n_bad++; $display("FAIL ramp_y got %0d want 100", box_y); end
    n_cmp++; if (moving !== 1'b1) begin n_bad++; $display("FAIL ramp_moving got %b want 1", moving); end
    btn_right = 1'b0;
  endtask

  task automatic test_frame_len();
    int t;
    do_reset();
    btn_left = 1'b1;
    for (int k = 0; k < 3; k++) begin
      do_frame(4, t);
      n_cmp++; if (t != 1) begin n_bad++; $display("FAIL long_se_ticks_f%0d got %0d want 1", k, t); end
    end
    n_cmp++; if (box_x !== 10'd97) begin n_bad++; $display("FAIL long_se_x got %0d want 97", box_x); end
    // Reset released while screen_end is already high: no update in that frame.
    @(negedge clk);
    reset = 1'b1;
    screen_end = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    t = 0;
    repeat (5) begin
      @(negedge clk);
      if (frame_tick === 1'b1) t++;
    end
    screen_end = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (t != 0) begin n_bad++; $display("FAIL se_high_reset_ticks got %0d want 0", t); end
    n_cmp++; if (box_x !== 10'd100) begin n_bad++; $display("FAIL se_high_reset_x got %0d want 100", box_x); end
    btn_left = 1'b0;
  endtask

  task automatic test_clamp();
    do_reset();
    btn_right = 1'b1;
    frames(25 + 109);
    n_cmp++; if (box_x !== 10'd588 || speed !== 3'd4) begin n_bad++; $display("FAIL clamp_pre_r got x=%0d s=%0d want 588 4", box_x, speed); end
    frames(1);
    n_cmp++; if (box_x !== 10'd590) begin n_bad++; $display("FAIL clamp_r1 got %0d want 590", box_x); end
    frames(1);
    n_cmp++; if (box_x !== 10'd590) begin n_bad++; $display("FAIL clamp_r2 got %0d want 590", box_x); end
    @(negedge clk);
    btn_right = 1'b0;
    btn_left  = 1'b1;
    frames(147);
    n_cmp++; if (box_x !== 10'd2 || speed !== 3'd4) begin n_bad++; $display("FAIL clamp_pre_l got x=%0d s=%0d want 2 4", box_x, speed); end
    frames(1);
    n_cmp++; if (box_x !== 10'd0) begin n_bad++; $display("FAIL clamp_l1 got %0d want 0", box_x); end
    frames(1);
    n_cmp++; if (box_x !== 10'd0) begin n_bad++; $display("FAIL clamp_l2 got %0d want 0", box_x); end
    btn_left = 1'b0;
  endtask

  task automatic test_cancel();
    do_reset();
    btn_right = 1'b1;
    frames(3);
    btn_left = 1'b1;
    frames(2);
    n_cmp++; if (box_x !== 10'd103) begin n_bad++; $display("FAIL cancel_x got %0d want 103", box_x); end
    n_cmp++; if (moving !== 1'b0 || speed !== 3'd1) begin n_bad++; $display("FAIL cancel_state got mov=%b s=%0d want 0 1", moving, speed); end
    btn_right = 1'b0;
    btn_left  = 1'b0;
  endtask

  task automatic test_keys();
    do_reset();
    send_byte(8'hE0); send_byte(8'h74);
    n_cmp++; if (key_held !== 4'b0100) begin n_bad++; $display("FAIL key_make got %b want 0100", key_held); end
    frames(1);
    n_cmp++; if (box_x !== 10'd101) begin n_bad++; $display("FAIL key_move got %0d want 101", box_x); end
    send_byte(8'hF0); send_byte(8'h74);
    n_cmp++; if (key_held !== 4'b0100) begin n_bad++; $display("FAIL key_plain_break got %b want 0100", key_held); end
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h74);
    n_cmp++; if (key_held !== 4'b0000) begin n_bad++; $display("FAIL key_ext_break got %b want 0000", key_held); end
    frames(1);
    n_cmp++; if (box_x !== 10'd101 || speed !== 3'd1 || moving !== 1'b0) begin n_bad++; $display("FAIL key_stop got x=%0d s=%0d mov=%b want 101 1 0", box_x, speed, moving); end
    send_byte(8'hE0); send_byte(8'h75);
    frames(1);
    n_cmp++; if (box_y !== 10'd99 || key_held !== 4'b1000) begin n_bad++; $display("FAIL key_up got y=%0d k=%b want 99 1000", box_y, key_held); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    btn_down = 1'b1;
    frames(16);
    n_cmp++; if (speed !== 3'd3 || box_y !== 10'd124) begin n_bad++; $display("FAIL mid_pre got s=%0d y=%0d want 3 124", speed, box_y); end
    send_byte(8'hE0); send_byte(8'h6B);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_cmp++; if (box_x !== 10'd100 || box_y !== 10'd100 || speed !== 3'd1) begin n_bad++; $display("FAIL mid_reset_pos got x=%0d y=%0d s=%0d want 100 100 1", box_x, box_y, speed); end
    n_cmp++; if (key_held !== 4'b0000 || frame_tick !== 1'b0) begin n_bad++; $display("FAIL mid_reset_flags got k=%b t=%b want 0000 0", key_held, frame_tick); end
    btn_down = 1'b0;
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_frame_len();
    test_clamp();
    test_cancel();
    test_keys();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
